// File: rtl/efpga_op_bridge.sv
// rtl/efpga_op_bridge.sv - Wishbone slave that queues operand/operator commands and sequences them onto the eFPGA port
module efpga_op_bridge #(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 2,
    parameter int DELAY_W = 4,
    parameter int NUM_RES = 3,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_we_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    output logic [DATA_W-1:0]         efpga_operand_a_o,
    output logic [DATA_W-1:0]         efpga_operand_b_o,
    output logic [OP_W-1:0]           efpga_operator_o,
    output logic [DELAY_W-1:0]        efpga_delay_o,
    output logic                      efpga_write_strobe_o,
    output logic                      efpga_en_o,
    input  logic                      efpga_fpga_done_i,
    input  logic [NUM_RES*DATA_W-1:0] efpga_result_i,
    output logic                      irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int EW = 2*DATA_W + OP_W + DELAY_W;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_ack;
    logic [31:0]        r_dat;
    logic [DATA_W-1:0]  r_opa, r_opb;
    logic [2:0]         r_irqen;
    logic [2:0]         r_flags;
    logic               r_irq;
    logic [EW-1:0]      r_mem [DEPTH];
    logic [AW-1:0]      r_wptr, r_rptr;
    logic [CW-1:0]      r_count;
    logic [DATA_W-1:0]  r_opa_o, r_opb_o;
    logic [OP_W-1:0]    r_op_o;
    logic [DELAY_W-1:0] r_dly_o;
    logic [DELAY_W-1:0] r_dcnt;
    logic [TW-1:0]      r_tcnt;
    logic [DATA_W-1:0]  r_res [NUM_RES];

    logic        w_req, w_wr, w_full, w_empty, w_cmd, w_push, w_ovf_set;
    logic        w_pop, w_strobe, w_en, w_to_set, w_done_set;
    logic [3:0]  w_idx;
    logic [2:0]  w_w1c;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Access is accepted only when no ack is pending, giving one-cycle acks with a gap
    assign w_req     = wbs_stb_i & wbs_cyc_i & ~r_ack;
    assign w_wr      = w_req & wbs_we_i;
    assign w_idx     = wbs_adr_i[5:2];
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_cmd     = w_wr && (w_idx == 4'd2);
    assign w_push    = w_cmd & ~w_full;
    assign w_ovf_set = w_cmd & w_full;
    assign w_w1c     = (w_wr && (w_idx == 4'd3)) ? wbs_dat_i[5:3] : 3'b000;
    assign w_unused  = &{1'b0, wbs_adr_i[31:6], wbs_adr_i[1:0], wbs_dat_i};

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_strobe    = 1'b0;
        w_en        = 1'b0;
        w_to_set    = 1'b0;
        w_done_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_strobe    = 1'b1;
                w_en        = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_en = 1'b1;
                if (r_dcnt == '0) begin
                    if (efpga_fpga_done_i) begin
                        w_state_nxt = S_CAPTURE;
                    end else if (r_tcnt == TW'(TIMEOUT-1)) begin
                        w_to_set    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_CAPTURE: begin
                w_done_set  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = 32'h0;
        case (w_idx)
            4'd0: w_rdata = 32'(r_opa);
            4'd1: w_rdata = 32'(r_opb);
            4'd3: w_rdata = {19'h0, 5'(r_count), 2'b00, r_flags, w_empty, w_full, r_state != S_IDLE};
            4'd4: w_rdata = {29'h0, r_irqen};
            default: begin
                for (int i = 0; i < NUM_RES; i++) begin
                    if (w_idx == 4'(8 + i)) w_rdata = 32'(r_res[i]);
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_dat   <= 32'h0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_irqen <= 3'b000;
            r_flags <= 3'b000;
            r_irq   <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_opa_o <= '0;
            r_opb_o <= '0;
            r_op_o  <= '0;
            r_dly_o <= '0;
            r_dcnt  <= '0;
            r_tcnt  <= '0;
            for (int i = 0; i < NUM_RES; i++) r_res[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_req;
            r_dat   <= w_req ? w_rdata : 32'h0;
            if (w_wr && (w_idx == 4'd0)) r_opa   <= wbs_dat_i[DATA_W-1:0];
            if (w_wr && (w_idx == 4'd1)) r_opb   <= wbs_dat_i[DATA_W-1:0];
            if (w_wr && (w_idx == 4'd4)) r_irqen <= wbs_dat_i[2:0];
            // Set events override a same-cycle W1C
            r_flags <= (r_flags & ~w_w1c) | {w_done_set, w_to_set, w_ovf_set};
            r_irq   <= |(r_flags & r_irqen);
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                {r_opa_o, r_opb_o, r_op_o, r_dly_o} <= r_mem[r_rptr];
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (r_state == S_ISSUE) begin
                r_dcnt <= r_dly_o;
                r_tcnt <= '0;
            end else if (r_state == S_WAIT) begin
                if (r_dcnt != '0) r_dcnt <= r_dcnt - 1'b1;
                else if (!efpga_fpga_done_i && !w_to_set) r_tcnt <= r_tcnt + 1'b1;
            end
            if (r_state == S_CAPTURE) begin
                for (int i = 0; i < NUM_RES; i++) r_res[i] <= efpga_result_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_push) r_mem[r_wptr] <= {r_opa, r_opb, wbs_dat_i[OP_W-1:0], wbs_dat_i[8 +: DELAY_W]};
    end

    assign wbs_ack_o            = r_ack;
    assign wbs_dat_o            = r_dat;
    assign efpga_operand_a_o    = r_opa_o;
    assign efpga_operand_b_o    = r_opb_o;
    assign efpga_operator_o     = r_op_o;
    assign efpga_delay_o        = r_dly_o;
    assign efpga_write_strobe_o = w_strobe;
    assign efpga_en_o           = w_en;
    assign irq_o                = r_irq;
endmodule
